// File: rtl/tl_rational_a_source.sv
// tl_rational_a_source: TileLink A-channel source half of a rational clock crossing.
// Define TL_RATIONAL_A_SOURCE_SKID_EN to insert a 2-entry FIFO in front of the crossing logic.
module tl_rational_a_source (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_enq_valid,
    output logic        o_enq_ready,
    input  logic [2:0]  i_enq_opcode,
    input  logic [2:0]  i_enq_param,
    input  logic [2:0]  i_enq_size,
    input  logic [6:0]  i_enq_source,
    input  logic [24:0] i_enq_address,
    input  logic [3:0]  i_enq_mask,
    input  logic [31:0] i_enq_data,
    input  logic        i_enq_corrupt,
    output logic [2:0]  o_deq_bits0_opcode,
    output logic [2:0]  o_deq_bits0_param,
    output logic [2:0]  o_deq_bits0_size,
    output logic [6:0]  o_deq_bits0_source,
    output logic [24:0] o_deq_bits0_address,
    output logic [3:0]  o_deq_bits0_mask,
    output logic [31:0] o_deq_bits0_data,
    output logic        o_deq_bits0_corrupt,
    output logic [2:0]  o_deq_bits1_opcode,
    output logic [2:0]  o_deq_bits1_param,
    output logic [2:0]  o_deq_bits1_size,
    output logic [6:0]  o_deq_bits1_source,
    output logic [24:0] o_deq_bits1_address,
    output logic [3:0]  o_deq_bits1_mask,
    output logic [31:0] o_deq_bits1_data,
    output logic        o_deq_bits1_corrupt,
    output logic        o_deq_valid,
    output logic [1:0]  o_deq_source,
    input  logic        i_deq_ready,
    input  logic [1:0]  i_deq_sink
);
    localparam int W = 78;
    logic [W-1:0] w_enq_bits, w_bits, r_bits1;
    logic         w_valid, w_ready, w_fire, w_equal, r_live;
    logic [1:0]   r_count;
    assign w_enq_bits = {i_enq_opcode, i_enq_param, i_enq_size, i_enq_source,
                         i_enq_address, i_enq_mask, i_enq_data, i_enq_corrupt};
    assign w_equal = r_count == i_deq_sink;
    // When not equal, accept unless count is already two Gray steps ahead (all bits differ).
    assign w_ready = r_live & (w_equal ? i_deq_ready : (r_count != ~i_deq_sink));
    assign w_fire  = w_valid & w_ready;
`ifdef TL_RATIONAL_A_SOURCE_SKID_EN
    logic [W-1:0] r_mem [2];
    logic         r_wp, r_rp, w_push;
    logic [1:0]   r_cnt;
    assign w_valid     = r_cnt != 2'd0;
    assign w_bits      = r_mem[r_rp];
    assign o_enq_ready = r_live & ((r_cnt != 2'd2) | w_fire);
    assign w_push      = i_enq_valid & o_enq_ready;
    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wp] <= w_enq_bits;
    end
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) r_wp <= ~r_wp;
            if (w_fire) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_fire};
        end
    end
`else
    assign w_valid     = r_live & i_enq_valid;
    assign w_bits      = w_enq_bits;
    assign o_enq_ready = w_ready;
`endif
    // r_live keeps the handshake closed until the first edge after reset release.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_live  <= 1'b0;
            r_count <= 2'b00;
            r_bits1 <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_fire) r_count <= {r_count[0], ~r_count[1]};
            if (w_equal) r_bits1 <= w_bits;
        end
    end
    assign o_deq_valid  = w_valid;
    assign o_deq_source = r_count;
    assign {o_deq_bits0_opcode, o_deq_bits0_param, o_deq_bits0_size, o_deq_bits0_source,
            o_deq_bits0_address, o_deq_bits0_mask, o_deq_bits0_data, o_deq_bits0_corrupt} = w_bits;
    assign {o_deq_bits1_opcode, o_deq_bits1_param, o_deq_bits1_size, o_deq_bits1_source,
            o_deq_bits1_address, o_deq_bits1_mask, o_deq_bits1_data, o_deq_bits1_corrupt} = r_bits1;
endmodule
